// File: rtl/inst_decode_stage_pkg.sv
// Shared types for the RV32I decode stage: opcode enum, decoded-instruction fields and buffer entry.
package inst_decode_stage_pkg;

    localparam int cInstWidth = 32;
    localparam int cRegIdxW   = 5;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'h03,
        OP_FENCE    = 7'h0F,
        OP_IMMEDI   = 7'h13,
        OP_AUIPC    = 7'h17,
        OP_STORE    = 7'h23,
        OP_RTYPE    = 7'h33,
        OP_LUI      = 7'h37,
        OP_BRANCH   = 7'h63,
        OP_JALR     = 7'h67,
        OP_JAL      = 7'h6F,
        OP_CNTRL_ST = 7'h73
    } tOpcodeEnum;

    typedef struct packed {
        logic                dv;
        logic [cRegIdxW-1:0] idx;
    } tRegSel;

    typedef struct packed {
        logic       dv;
        logic [2:0] val;
    } tFunct3;

    typedef struct packed {
        logic       dv;
        logic [6:0] val;
    } tFunct7;

    typedef struct packed {
        logic        dv;
        logic [31:0] val;
    } tImm;

    typedef struct packed {
        tRegSel rs1;
        tRegSel rs2;
        tRegSel rd;
        tFunct3 funct3;
        tFunct7 funct7;
        tImm    imm;
    } tDecodedInst;

    // The PC travels beside this entry because its width is a module parameter.
    typedef struct packed {
        tDecodedInst dec;
        tOpcodeEnum  op;
        logic        illegal;
    } tDecStageEntry;

endpackage

// File: rtl/inst_decode_stage_fifo.sv
// Synchronous FIFO with occupancy count and modulo pointers, so any depth >= 1 works.
module sync_fifo #(
    parameter int pWidth = 8,
    parameter int pDepth = 2,
    localparam int cCntW = $clog2(pDepth + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [pWidth-1:0] i_wr_data,
    output logic [pWidth-1:0] o_rd_data,
    output logic [cCntW-1:0]  o_count
);

    localparam int cPtrW = (pDepth > 1) ? $clog2(pDepth) : 1;
    localparam logic [cPtrW-1:0] cLastPtr = cPtrW'(pDepth - 1);
    localparam logic [cCntW-1:0] cFull    = cCntW'(pDepth);

    logic [pWidth-1:0] r_mem [pDepth];
    logic [cPtrW-1:0]  r_wr_ptr;
    logic [cPtrW-1:0]  r_rd_ptr;
    logic [cCntW-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [cPtrW-1:0] next_ptr(input logic [cPtrW-1:0] ptr);
        return (ptr == cLastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign w_do_push = i_push && (r_count != cFull);
    assign w_do_pop  = i_pop && (r_count != '0);

    // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the count alone decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/inst_decode_stage.sv
// Registered RV32I decode stage: combinational decode into a buffered FIFO of decoded entries.
// Define DECODE_ILLEGAL_CHK_EN to add the illegal-instruction check on illegalOut.
module inst_decode_stage
    import inst_decode_stage_pkg::*;
#(
    parameter int pPcWidth    = 32,
    parameter int pBufDepth   = 2,
    parameter int pRegSelBitW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  validIn,
    output logic                  readyOut,
    input  logic [cInstWidth-1:0] instIn,
    input  logic [pPcWidth-1:0]   pcIn,
    output logic                  validOut,
    input  logic                  readyIn,
    output tDecodedInst           decOut,
    output logic [6:0]            opcodeOut,
    output logic [pPcWidth-1:0]   pcOut,
    output logic                  illegalOut
);

    localparam int cCntW   = $clog2(pBufDepth + 1);
    localparam int cEntryW = $bits(tDecStageEntry) + pPcWidth;

    if ((pBufDepth < 1) || (pBufDepth > 8)) begin : g_bad_depth
        $error("inst_decode_stage: pBufDepth must be within 1..8");
    end
    if ((pRegSelBitW != 4) && (pRegSelBitW != 5)) begin : g_bad_regsel
        $error("inst_decode_stage: pRegSelBitW must be 4 or 5");
    end

    tOpcodeEnum          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [31:0]         w_imm_i;
    logic [31:0]         w_imm_s;
    logic [31:0]         w_imm_b;
    logic [31:0]         w_imm_u;
    logic [31:0]         w_imm_j;
    tDecodedInst         w_dec;
    logic                w_known;
    logic                w_illegal;
    tDecStageEntry       w_push_entry;
    tDecStageEntry       w_head_entry;
    logic [pPcWidth-1:0] w_head_pc;
    logic [cEntryW-1:0]  w_rd_data;
    logic [cCntW-1:0]    w_count;
    logic                w_push;
    logic                w_pop;

    assign w_opcode = tOpcodeEnum'(instIn[6:0]);
    assign w_funct3 = instIn[14:12];
    assign w_funct7 = instIn[31:25];

    assign w_imm_i = {{20{instIn[31]}}, instIn[31:20]};
    assign w_imm_s = {{20{instIn[31]}}, instIn[31:25], instIn[11:7]};
    assign w_imm_b = {{19{instIn[31]}}, instIn[31], instIn[7], instIn[30:25], instIn[11:8], 1'b0};
    assign w_imm_u = {instIn[31:12], 12'b0};
    assign w_imm_j = {{11{instIn[31]}}, instIn[31], instIn[19:12], instIn[20], instIn[30:21], 1'b0};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_dec            = '0;
        w_dec.rs1.idx    = instIn[19:15];
        w_dec.rs2.idx    = instIn[24:20];
        w_dec.rd.idx     = instIn[11:7];
        w_dec.funct3.val = w_funct3;
        w_dec.funct7.val = w_funct7;
        w_known          = 1'b1;
        w_illegal        = 1'b0;

        case (w_opcode)
            OP_LOAD, OP_JALR, OP_IMMEDI: begin
                w_dec.rs1.dv    = 1'b1;
                w_dec.rd.dv     = 1'b1;
                w_dec.funct3.dv = 1'b1;
                w_dec.imm.dv    = 1'b1;
                w_dec.imm.val   = w_imm_i;
                // Shift-immediates carry funct7 and an unsigned 5-bit shamt.
                if ((w_opcode == OP_IMMEDI) && ((w_funct3 == 3'd1) || (w_funct3 == 3'd5))) begin
                    w_dec.funct7.dv = 1'b1;
                    w_dec.imm.val   = {27'd0, instIn[24:20]};
                end
            end
            OP_STORE, OP_BRANCH: begin
                w_dec.rs1.dv    = 1'b1;
                w_dec.rs2.dv    = 1'b1;
                w_dec.funct3.dv = 1'b1;
                w_dec.imm.dv    = 1'b1;
                w_dec.imm.val   = (w_opcode == OP_STORE) ? w_imm_s : w_imm_b;
            end
            OP_RTYPE: begin
                w_dec.rs1.dv    = 1'b1;
                w_dec.rs2.dv    = 1'b1;
                w_dec.rd.dv     = 1'b1;
                w_dec.funct3.dv = 1'b1;
                w_dec.funct7.dv = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_dec.rd.dv   = 1'b1;
                w_dec.imm.dv  = 1'b1;
                w_dec.imm.val = w_imm_u;
            end
            OP_JAL: begin
                w_dec.rd.dv   = 1'b1;
                w_dec.imm.dv  = 1'b1;
                w_dec.imm.val = w_imm_j;
            end
            OP_FENCE: begin
                w_dec.funct3.dv = 1'b1;
            end
            OP_CNTRL_ST: begin
                w_dec.funct3.dv = 1'b1;
                w_dec.imm.dv    = 1'b1;
                w_dec.imm.val   = w_imm_i;
                w_dec.rs1.dv    = (w_funct3 != 3'd0);
                w_dec.rd.dv     = (w_funct3 != 3'd0);
            end
            default: begin
                w_known = 1'b0;
            end
        endcase

`ifdef DECODE_ILLEGAL_CHK_EN
        case (w_opcode)
            OP_LOAD:   w_illegal = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
            OP_STORE:  w_illegal = (w_funct3 > 3'd2);
            OP_BRANCH: w_illegal = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
            OP_JALR:   w_illegal = (w_funct3 != 3'd0);
            OP_RTYPE:  w_illegal = !((w_funct7 == 7'h00) ||
                                     ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5))));
            OP_IMMEDI: w_illegal = ((w_funct3 == 3'd1) && (w_funct7 != 7'h00)) ||
                                   ((w_funct3 == 3'd5) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20));
            default:   w_illegal = !w_known;
        endcase
        if (instIn[1:0] != 2'b11) w_illegal = 1'b1;
        // RV32E has only 16 registers, so any used index with bit 4 set is out of range.
        if ((pRegSelBitW == 4) &&
            ((w_dec.rs1.dv && w_dec.rs1.idx[4]) ||
             (w_dec.rs2.dv && w_dec.rs2.idx[4]) ||
             (w_dec.rd.dv  && w_dec.rd.idx[4]))) begin
            w_illegal = 1'b1;
        end
        if (w_illegal) begin
            w_dec.rs1.dv    = 1'b0;
            w_dec.rs2.dv    = 1'b0;
            w_dec.rd.dv     = 1'b0;
            w_dec.funct3.dv = 1'b0;
            w_dec.funct7.dv = 1'b0;
            w_dec.imm.dv    = 1'b0;
        end
`else
        w_illegal = 1'b0;
`endif
    end

    assign w_push_entry = '{dec: w_dec, op: w_opcode, illegal: w_illegal};

    // readyOut looks only at the registered count, never at readyIn.
    assign readyOut = !rst && (w_count < cCntW'(pBufDepth));
    assign validOut = (w_count != '0);
    assign w_push   = validIn && readyOut && !flush;
    assign w_pop    = validOut && readyIn;

    sync_fifo #(
        .pWidth (cEntryW),
        .pDepth (pBufDepth)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (flush),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data ({w_push_entry, pcIn}),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    assign {w_head_entry, w_head_pc} = w_rd_data;

    assign decOut     = validOut ? w_head_entry.dec : '0;
    assign opcodeOut  = validOut ? w_head_entry.op : 7'h00;
    assign pcOut      = validOut ? w_head_pc : '0;
    assign illegalOut = validOut && w_head_entry.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed cases plus random traffic against a queue model.
module tb_inst_decode_stage;
    import inst_decode_stage_pkg::*;

    localparam int cDepth = 2;

    typedef struct {
        tDecodedInst dec;
        logic [6:0]  op;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst, flush, validIn, readyIn;
    logic [31:0] instIn, pcIn;
    logic        readyOut, validOut, illegalOut;
    tDecodedInst decOut;
    logic [6:0]  opcodeOut;
    logic [31:0] pcOut;

    logic        e_rst, e_flush, e_validIn, e_readyIn;
    logic [31:0] e_instIn, e_pcIn;
    logic        e_readyOut, e_validOut, e_illegalOut;
    tDecodedInst e_decOut;
    logic [6:0]  e_opcodeOut;
    logic [31:0] e_pcOut;

    int   n_vec;
    int   n_miss;
    exp_t q[$];
    bit   m_fresh;
    bit   m_push;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inst_decode_stage #(.pPcWidth(32), .pBufDepth(cDepth), .pRegSelBitW(5)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .validIn(validIn), .readyOut(readyOut),
        .instIn(instIn), .pcIn(pcIn), .validOut(validOut), .readyIn(readyIn),
        .decOut(decOut), .opcodeOut(opcodeOut), .pcOut(pcOut), .illegalOut(illegalOut)
    );

    inst_decode_stage #(.pPcWidth(32), .pBufDepth(3), .pRegSelBitW(4)) u_dut_e (
        .clk(clk), .rst(e_rst), .flush(e_flush), .validIn(e_validIn), .readyOut(e_readyOut),
        .instIn(e_instIn), .pcIn(e_pcIn), .validOut(e_validOut), .readyIn(e_readyIn),
        .decOut(e_decOut), .opcodeOut(e_opcodeOut), .pcOut(e_pcOut), .illegalOut(e_illegalOut)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        int s;
        s = int'(v << (32 - n));
        return 32'(s >>> (32 - n));
    endfunction

    function automatic logic [5:0] dv_bits(input tDecodedInst d);
        return {d.rs1.dv, d.rs2.dv, d.rd.dv, d.funct3.dv, d.funct7.dv, d.imm.dv};
    endfunction

    // Reference decoder built straight from the instruction-format tables.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit rv32e);
        exp_t        e;
        int          f3, f7;
        bit          u_rs1, u_rs2, u_rd, u_f3, u_f7, u_imm, bad;
        logic [31:0] imm;
        logic [12:0] b13;
        logic [20:0] j21;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        u_rs1 = 0; u_rs2 = 0; u_rd = 0; u_f3 = 0; u_f7 = 0; u_imm = 0; bad = 0;
        imm = '0;
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h03: begin u_rs1 = 1; u_rd = 1; u_f3 = 1; u_imm = 1; imm = sext(32'(w[31:20]), 12);
                         bad = (f3 == 3) || (f3 == 6) || (f3 == 7); end
            7'h67: begin u_rs1 = 1; u_rd = 1; u_f3 = 1; u_imm = 1; imm = sext(32'(w[31:20]), 12);
                         bad = (f3 != 0); end
            7'h13: begin
                u_rs1 = 1; u_rd = 1; u_f3 = 1; u_imm = 1;
                if (f3 == 1 || f3 == 5) begin
                    u_f7 = 1;
                    imm  = 32'(w[24:20]);
                    bad  = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 32);
                end else begin
                    imm = sext(32'(w[31:20]), 12);
                end
            end
            7'h23: begin u_rs1 = 1; u_rs2 = 1; u_f3 = 1; u_imm = 1;
                         imm = sext(32'({w[31:25], w[11:7]}), 12); bad = (f3 > 2); end
            7'h63: begin u_rs1 = 1; u_rs2 = 1; u_f3 = 1; u_imm = 1;
                         imm = sext(32'(b13), 13); bad = (f3 == 2) || (f3 == 3); end
            7'h33: begin u_rs1 = 1; u_rs2 = 1; u_rd = 1; u_f3 = 1; u_f7 = 1;
                         bad = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))); end
            7'h37, 7'h17: begin u_rd = 1; u_imm = 1; imm = 32'(w[31:12]) * 4096; end
            7'h6F: begin u_rd = 1; u_imm = 1; imm = sext(32'(j21), 21); end
            7'h0F: begin u_f3 = 1; end
            7'h73: begin u_f3 = 1; u_imm = 1; imm = sext(32'(w[31:20]), 12);
                         u_rs1 = (f3 != 0); u_rd = (f3 != 0); end
            default: bad = 1;
        endcase
        if (rv32e && ((u_rs1 && w[19]) || (u_rs2 && w[24]) || (u_rd && w[11]))) bad = 1;
`ifdef DECODE_ILLEGAL_CHK_EN
        if (bad) begin
            u_rs1 = 0; u_rs2 = 0; u_rd = 0; u_f3 = 0; u_f7 = 0; u_imm = 0;
        end
        e.ill = bad;
`else
        e.ill = 1'b0;
`endif
        e.dec            = '0;
        e.dec.rs1.idx    = w[19:15];
        e.dec.rs2.idx    = w[24:20];
        e.dec.rd.idx     = w[11:7];
        e.dec.rs1.dv     = u_rs1;
        e.dec.rs2.dv     = u_rs2;
        e.dec.rd.dv      = u_rd;
        e.dec.funct3.dv  = u_f3;
        e.dec.funct3.val = w[14:12];
        e.dec.funct7.dv  = u_f7;
        e.dec.funct7.val = w[31:25];
        e.dec.imm.dv     = u_imm;
        e.dec.imm.val    = imm;
        e.op             = w[6:0];
        e.pc             = pc;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 13);
        if (sel < 11) w[6:0] = ops[sel];
        if ($urandom_range(0, 2) == 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic apply(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit rdy, input bit fl, input bit r);
        validIn = v; instIn = inst; pcIn = pc; readyIn = rdy; flush = fl; rst = r;
    endtask

    task automatic sample();
        exp_t h;
        @(negedge clk);
        check("validOut", 64'(validOut), 64'(q.size() != 0));
        check("readyOut", 64'(readyOut), 64'(!rst && (q.size() < cDepth)));
        if (q.size() != 0) begin
            h = q[0];
            check("head.dv", 64'(dv_bits(decOut)), 64'(dv_bits(h.dec)));
            check("head.regidx", 64'({decOut.rs1.idx, decOut.rs2.idx, decOut.rd.idx}),
                  64'({h.dec.rs1.idx, h.dec.rs2.idx, h.dec.rd.idx}));
            check("head.op", 64'(opcodeOut), 64'(h.op));
            check("head.pc", 64'(pcOut), 64'(h.pc));
            check("head.illegal", 64'(illegalOut), 64'(h.ill));
            if (h.dec.funct3.dv) check("head.funct3", 64'(decOut.funct3.val), 64'(h.dec.funct3.val));
            if (h.dec.funct7.dv) check("head.funct7", 64'(decOut.funct7.val), 64'(h.dec.funct7.val));
            if (h.dec.imm.dv)    check("head.imm", 64'(decOut.imm.val), 64'(h.dec.imm.val));
        end else if (m_fresh) begin
            check("rstval.dec", 64'(decOut), 64'(0));
            check("rstval.op_pc_ill", 64'({opcodeOut, pcOut, illegalOut}), 64'(0));
        end
    endtask

    task automatic commit();
        bit   r, fl, push, pop;
        exp_t e;
        r    = rst;
        fl   = flush;
        push = validIn && !r && (q.size() < cDepth) && !fl;
        pop  = (q.size() != 0) && readyIn;
        e    = ref_decode(instIn, pcIn, 1'b0);
        @(posedge clk);
        m_push = 1'b0;
        if (r || fl) begin
            q.delete();
            if (r) m_fresh = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                m_push  = 1'b1;
                m_fresh = 1'b0;
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        commit();
    endtask

    initial begin
        logic [31:0] e_prog [4];
        bit          acc;
        n_vec = 0; n_miss = 0; m_fresh = 1'b0; m_push = 1'b0;
        e_prog = '{32'h00208833, 32'h003100B3, 32'h00510113, 32'h00718193};
        e_rst = 1'b1; e_flush = 1'b0; e_validIn = 1'b0; e_readyIn = 1'b0;
        e_instIn = '0; e_pcIn = '0;
        apply(0, 0, 0, 1, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        m_fresh = 1'b1;

        // While held in reset: not ready, outputs at reset values.
        step();
        apply(0, 0, 0, 1, 0, 0);
        step();

        // addi x1,x2,-1
        apply(1, 32'hFFF10093, 32'h0000_1000, 1, 0, 0);
        step();
        apply(0, 0, 0, 1, 0, 0);
        sample();
        check("t1.op", 64'(opcodeOut), 64'h13);
        check("t1.rd", 64'({decOut.rd.dv, decOut.rd.idx}), 64'({1'b1, 5'd1}));
        check("t1.rs1", 64'({decOut.rs1.dv, decOut.rs1.idx}), 64'({1'b1, 5'd2}));
        check("t1.imm", 64'({decOut.imm.dv, decOut.imm.val}), 64'({1'b1, 32'hFFFF_FFFF}));
        check("t1.rs2dv", 64'(decOut.rs2.dv), 64'(0));
        check("t1.funct3", 64'({decOut.funct3.dv, decOut.funct3.val}), 64'({1'b1, 3'd0}));
        commit();

        // beq x1,x2,-4
        apply(1, 32'hFE208EE3, 32'h0000_1004, 1, 0, 0);
        step();
        apply(0, 0, 0, 1, 0, 0);
        sample();
        check("t2.imm", 64'(decOut.imm.val), 64'hFFFF_FFFC);
        check("t2.rs1rs2", 64'({decOut.rs1.idx, decOut.rs2.idx}), 64'({5'd1, 5'd2}));
        check("t2.rd_f7_dv", 64'({decOut.rd.dv, decOut.funct7.dv}), 64'(0));
        commit();

        // Back-pressure: fill, third held, then drain with no bubble.
        apply(1, 32'h00100093, 32'h2000, 0, 0, 0); step();
        apply(1, 32'h00200113, 32'h2004, 0, 0, 0); step();
        apply(1, 32'h00300193, 32'h2008, 0, 0, 0);
        sample();
        check("t3.full_notready", 64'(readyOut), 64'(0));
        commit();
        apply(1, 32'h00300193, 32'h2008, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t3.no_bubble", 64'(validOut), 64'(1));
            check("t3.order", 64'(pcOut), 64'(32'h2000 + 32'(4 * k)));
            commit();
            if (m_push) validIn = 1'b0;
        end
        apply(0, 0, 0, 1, 0, 0); step();

        // Flush while full with a simultaneous offer.
        apply(1, 32'h00100093, 32'h3000, 0, 0, 0); step();
        apply(1, 32'h00200113, 32'h3004, 0, 0, 0); step();
        apply(1, 32'h00300193, 32'h3008, 0, 1, 0); step();
        apply(0, 0, 0, 0, 0, 0);
        sample();
        check("t4.flush_valid", 64'(validOut), 64'(0));
        check("t4.flush_ready", 64'(readyOut), 64'(1));
        commit();
        // Reset mid-stream with a simultaneous offer.
        apply(1, 32'h00100093, 32'h3100, 0, 0, 0); step();
        apply(1, 32'h00200113, 32'h3104, 0, 0, 1); step();
        apply(0, 0, 0, 1, 0, 0);
        sample();
        check("t4.rst_valid", 64'(validOut), 64'(0));
        check("t4.rst_ready", 64'(readyOut), 64'(1));
        check("t4.rst_pc", 64'(pcOut), 64'(0));
        commit();

        // All-zero word.
        apply(1, 32'h0000_0000, 32'h4000, 1, 0, 0); step();
        apply(0, 0, 0, 1, 0, 0);
        sample();
        check("t5.op", 64'(opcodeOut), 64'(0));
        check("t5.dv", 64'(dv_bits(decOut)), 64'(0));
`ifdef DECODE_ILLEGAL_CHK_EN
        check("t5.illegal", 64'(illegalOut), 64'(1));
`else
        check("t5.illegal", 64'(illegalOut), 64'(0));
`endif
        commit();

        // add x16,x1,x2 on the RV32I build.
        apply(1, 32'h00208833, 32'h5000, 1, 0, 0); step();
        apply(0, 0, 0, 1, 0, 0);
        sample();
        check("t6.rd16", 64'({decOut.rd.dv, decOut.rd.idx}), 64'({1'b1, 5'd16}));
        check("t6.illegal", 64'(illegalOut), 64'(0));
        commit();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
            step();
        end
        apply(0, 0, 0, 1, 0, 0);
        step();
        step();

        // RV32E instance, depth 3: fill, hold a fourth, drain across the pointer wrap.
        e_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_validIn = 1'b1; e_instIn = e_prog[i]; e_pcIn = 32'h100 + 32'(4 * i);
            @(posedge clk); #1;
        end
        e_instIn = e_prog[3]; e_pcIn = 32'h10C;
        @(negedge clk);
        check("e.full_notready", 64'(e_readyOut), 64'(0));
        check("e.full_valid", 64'(e_validOut), 64'(1));
        @(posedge clk); #1;
        e_readyIn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("e.order", 64'(e_pcOut), 64'(32'h100 + 32'(4 * k)));
            if (k == 0) begin
`ifdef DECODE_ILLEGAL_CHK_EN
                check("e.x16_illegal", 64'(e_illegalOut), 64'(1));
                check("e.x16_dv", 64'(dv_bits(e_decOut)), 64'(0));
`else
                check("e.x16_illegal", 64'(e_illegalOut), 64'(0));
                check("e.x16_rd", 64'({e_decOut.rd.dv, e_decOut.rd.idx}), 64'({1'b1, 5'd16}));
`endif
            end
            if (k == 1) check("e.legal_add", 64'(e_illegalOut), 64'(0));
            acc = e_validIn && e_readyOut;
            @(posedge clk); #1;
            if (acc) e_validIn = 1'b0;
        end
        @(negedge clk);
        check("e.drained", 64'(e_validOut), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
